key_event: RTL and testbench
============================

KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_CNT, default 50_000_000, hold cycles before a long press (1 s at 50 MHz).
REQ-002 Parameter DBL_CNT, default 15_000_000, max release-to-press gap for a double click (300 ms).
REQ-003 Parameter REPEAT_CNT, default 5_000_000, auto-repeat period while long-held (100 ms).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 key_flag  input  1  one-cycle debounced key event strobe from the debounce stage.
REQ-007 key_state  input  1  debounced level qualifying key_flag: 0 = pressed, 1 = released.
REQ-008 single_click  output  1  one-cycle pulse, single click recognised.
REQ-009 double_click  output  1  one-cycle pulse, double click recognised.
REQ-010 long_press  output  1  one-cycle pulse, long-press threshold reached.
REQ-011 repeat_pulse  output  1  one-cycle pulse per repeat period while long-held (see Configuration).
REQ-012 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-013 Press event = key_flag & !key_state; release event = key_flag & key_state; key_state ignored when key_flag low.
REQ-014 FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG; one 26-bit counter cnt, cleared on every state transition, else increments, saturating at all-ones.
REQ-015 IDLE: press -> PRESS1; release ignored.
REQ-016 PRESS1: release -> WAIT2; else cnt == LONG_CNT-1 -> LONG with long_press pulse; release has priority in the same cycle.
REQ-017 WAIT2: press -> PRESS2; else cnt == DBL_CNT-1 -> IDLE with single_click pulse; press has priority in the same cycle.
REQ-018 PRESS2: release -> IDLE with double_click pulse; no long-press detection in PRESS2; press events ignored.
REQ-019 LONG: release -> IDLE, no pulse; press events ignored.
REQ-020 All outputs registered; each pulse asserted exactly the cycle after the triggering event/terminal count is sampled, for exactly one cycle.
REQ-021 At most one of single_click, double_click, long_press, repeat_pulse high in any cycle.
REQ-022 busy reflects the registered state (high the cycle after entering PRESS1, low the cycle after returning to IDLE).
REQ-023 A press arriving in the same cycle a pulse is issued on return to IDLE is lost; new sequence starts only from IDLE on a later press.

Reset
REQ-024 rst high at a clock edge: state = IDLE, cnt = 0, all outputs 0, regardless of state or pending pulse.
REQ-025 Reset mid-sequence discards the sequence; no pulse issued after rst deasserts until a new press.

Configuration
REQ-026 Macro KEY_EVENT_REPEAT_EN defined: in LONG, repeat_pulse issued every REPEAT_CNT cycles after long_press (first at REPEAT_CNT cycles after long_press), repeat counter restarting each pulse; release stops it immediately.
REQ-027 KEY_EVENT_REPEAT_EN undefined: repeat_pulse tied 0, no repeat counter logic; port retained.

Structure
REQ-028 Shared package key_event_pkg: FSM state typedef, 26-bit counter width constant, default LONG_CNT/DBL_CNT/REPEAT_CNT constants.
REQ-029 Sub-module key_event_timer: clear/enable inputs, terminal-count compare against a parameter, saturating count; instantiated for state timing and (with macro) repeat timing.

Verification (LONG_CNT=100, DBL_CNT=40, REPEAT_CNT=20)
REQ-030 Press, release after 10 cycles, no further press -> single_click one cycle, 41 cycles after the release event; busy low next cycle.
REQ-031 Press, release after 10, press 20 cycles later, release after 10 -> double_click one cycle after second release; no single_click.
REQ-032 Press held 300 cycles -> long_press one cycle, 101 cycles after press; with KEY_EVENT_REPEAT_EN repeat_pulse at +20, +40 ... until release; without, repeat_pulse stays 0.
REQ-033 Press with release exactly on cycle cnt == 99 -> no long_press, enters WAIT2; press exactly on WAIT2 cnt == 39 -> PRESS2, no single_click.
REQ-034 rst asserted during WAIT2 -> all outputs 0 next cycle, no single_click ever; isolated release event in IDLE -> no output change.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and constants for the key_event click/long-press classifier.
package key_event_pkg;

  localparam int unsigned CNT_W              = 26;
  localparam int unsigned LONG_CNT_DEFAULT   = 50_000_000;
  localparam int unsigned DBL_CNT_DEFAULT    = 15_000_000;
  localparam int unsigned REPEAT_CNT_DEFAULT = 5_000_000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

endpackage

// File: rtl/key_event_timer.sv
// Saturating up-counter with a terminal-count flag against one of two parameter limits.
module key_event_timer
  import key_event_pkg::*;
#(
  parameter int unsigned TC_A = 1,
  parameter int unsigned TC_B = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt;

  // Holds at all-ones so a forgotten timer never wraps into a false terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == (sel ? CNT_W'(TC_B - 1) : CNT_W'(TC_A - 1)));

endmodule

// File: rtl/key_event.sv
// Classifies debounced key events into single/double click, long press and optional
// auto-repeat. Define KEY_EVENT_REPEAT_EN to enable repeat_pulse while long-held.
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CNT   = LONG_CNT_DEFAULT,
  parameter int unsigned DBL_CNT    = DBL_CNT_DEFAULT,
  parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_state,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

  if ((LONG_CNT < 2) || (DBL_CNT < 2) || (REPEAT_CNT < 2) ||
      (64'(LONG_CNT) > CNT_SPAN) || (64'(DBL_CNT) > CNT_SPAN) ||
      (64'(REPEAT_CNT) > CNT_SPAN)) begin : g_cfg_err
    $error("key_event: counts must lie in [2, 2**CNT_W]");
  end

  state_t state, state_nx;
  logic   press_c, release_c;
  logic   tc_c, clr_c;
  logic   single_nx, double_nx, long_nx, repeat_nx;

  assign press_c   = key_flag & ~key_state;
  assign release_c = key_flag &  key_state;
  assign clr_c     = (state_nx != state);

  // One shared state timer; the compare limit follows the state that is timing.
  key_event_timer #(
    .TC_A (LONG_CNT),
    .TC_B (DBL_CNT)
  ) u_state_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .en   (1'b1),
    .sel  (state == WAIT2),
    .tc_c (tc_c)
  );

  always_comb begin
    state_nx  = state;
    single_nx = 1'b0;
    double_nx = 1'b0;
    long_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_c) state_nx = PRESS1;
      end
      PRESS1: begin
        if (release_c) begin
          state_nx = WAIT2;
        end else if (tc_c) begin
          state_nx = LONG;
          long_nx  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_c) begin
          state_nx = PRESS2;
        end else if (tc_c) begin
          state_nx  = IDLE;
          single_nx = 1'b1;
        end
      end
      PRESS2: begin
        if (release_c) begin
          state_nx  = IDLE;
          double_nx = 1'b1;
        end
      end
      LONG: begin
        if (release_c) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef KEY_EVENT_REPEAT_EN
  logic rep_tc_c;

  // Restarts on entry to LONG and after every repeat pulse.
  key_event_timer #(
    .TC_A (REPEAT_CNT),
    .TC_B (REPEAT_CNT)
  ) u_repeat_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state != LONG) | rep_tc_c),
    .en   (1'b1),
    .sel  (1'b0),
    .tc_c (rep_tc_c)
  );

  assign repeat_nx = (state == LONG) & ~release_c & rep_tc_c;
`else
  assign repeat_nx = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      single_click <= single_nx;
      double_click <= double_nx;
      long_press   <= long_nx;
      repeat_pulse <= repeat_nx;
      busy         <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: expected pulses queued at stimulus time, matched at output.
module tb_key_event;

  localparam int unsigned LC = 100;
  localparam int unsigned DC = 40;
  localparam int unsigned RC = 20;

  localparam logic [3:0] K_SGL = 4'b0001;
  localparam logic [3:0] K_DBL = 4'b0010;
  localparam logic [3:0] K_LNG = 4'b0100;
  localparam logic [3:0] K_REP = 4'b1000;

  typedef struct {
    logic [3:0] kind;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic single_click, double_click, long_press, repeat_pulse, busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  key_event #(
    .LONG_CNT   (LC),
    .DBL_CNT    (DC),
    .REPEAT_CNT (RC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_flag     (key_flag),
    .key_state    (key_state),
    .single_click (single_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every pulse seen must match the head of the scoreboard in kind and cycle.
  always @(negedge clk) begin
    logic [3:0] code;
    exp_t       e;
    code = {repeat_pulse, long_press, double_click, single_click};
    if (code != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'(code), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", int'(code), int'(e.kind));
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic st);
    key_flag  = 1'b1;
    key_state = st;
    @(posedge clk);
    #1;
    key_flag = 1'b0;
  endtask

  task automatic sample_busy(input string tag, input logic exp);
    @(negedge clk);
    chk(tag, int'(busy), int'(exp));
  endtask

  task automatic sample_all_low(input string tag);
    @(negedge clk);
    chk(tag, int'({repeat_pulse, long_press, double_click, single_click, busy}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int p;
    int r;

    repeat (3) @(posedge clk);
    #1;
    sample_all_low("reset_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    goto(cyc + 3);
    sample_all_low("idle_after_reset");

    // Single click: pulse 41 cycles after the release event.
    p = cyc;
    drive(1'b0);
    sample_busy("busy_press1", 1'b1);
    goto(p + 10);
    r = cyc;
    drive(1'b1);
    sb.push_back('{K_SGL, r + 41});
    goto(r + 40);
    sample_busy("busy_wait2", 1'b1);
    goto(r + 42);
    sample_busy("busy_after_single", 1'b0);

    // Double click within the gap.
    p = cyc;
    drive(1'b0);
    goto(p + 10);
    drive(1'b1);
    goto(p + 30);
    drive(1'b0);
    goto(p + 40);
    r = cyc;
    drive(1'b1);
    sb.push_back('{K_DBL, r + 1});
    goto(r + 1);
    sample_busy("busy_after_double", 1'b0);
    goto(r + 60);

    // Long press held 300 cycles, with auto-repeat when enabled.
    p = cyc;
    drive(1'b0);
    sb.push_back('{K_LNG, p + 101});
`ifdef KEY_EVENT_REPEAT_EN
    for (int k = p + 101 + 20; k <= p + 300; k += 20) sb.push_back('{K_REP, k});
`endif
    goto(p + 200);
    sample_busy("busy_long", 1'b1);
    goto(p + 300);
    drive(1'b1);
    sample_busy("busy_after_long", 1'b0);
    goto(p + 340);

    // Release exactly at the long threshold, press exactly at the double-click threshold.
    p = cyc;
    drive(1'b0);
    goto(p + 100);
    drive(1'b1);
    goto(p + 140);
    drive(1'b0);
    goto(p + 150);
    drive(1'b1);
    sb.push_back('{K_DBL, p + 151});
    goto(p + 220);
    sample_busy("busy_after_boundary", 1'b0);

    // Reset during WAIT2 discards the pending single click.
    p = cyc;
    drive(1'b0);
    goto(p + 10);
    drive(1'b1);
    goto(p + 30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample_all_low("outputs_after_mid_reset");
    goto(p + 120);
    sample_busy("busy_after_mid_reset", 1'b0);

    // Isolated release in IDLE changes nothing.
    drive(1'b1);
    sample_all_low("release_in_idle");
    goto(cyc + 5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
